// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / hazard controller.
//   - forwarding-mux select encoding (fixed, 3 bits)
//   - register address width default
//   - per-stage destination tag layout {valid, wa, we, load, link}
//   - tag match helper and FSM state type
package fwd_pkg;

    localparam int REG_AW = 5;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] FWD_RF    = 3'd0;  // regfile operand
    localparam logic [SEL_W-1:0] FWD_EXMEM = 3'd1;  // EX/MEM ALU result
    localparam logic [SEL_W-1:0] FWD_MEMWB = 3'd2;  // MEM/WB write data
    localparam logic [SEL_W-1:0] FWD_LINK  = 3'd3;  // EX/MEM link value (PC+8)

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] wa;
        logic              we;
        logic              load;
        logic              link;
    } stage_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Register 0 is hardwired, so it never matches a producer.
    function automatic logic tag_match(input stage_tag_t t, input logic [REG_AW-1:0] r);
        return t.valid & t.we & (t.wa != '0) & (t.wa == r);
    endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// Priority forwarding select for one ALU operand.
// Ports:
//   use_r    in   operand is actually read by the ID instruction
//   r        in   source register address
//   ex_tag   in   tag of instruction currently in EX
//   mem_tag  in   tag of instruction currently in MEM
//   sel      out  forwarding-mux select (FWD_* encoding)
// The newest producer wins: EX is checked before MEM.
module fwd_sel_calc
    import fwd_pkg::*;
(
    input  logic              use_r,
    input  logic [REG_AW-1:0] r,
    input  stage_tag_t        ex_tag,
    input  stage_tag_t        mem_tag,
    output logic [SEL_W-1:0]  sel
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = tag_match(ex_tag, r);
    assign mem_hit = tag_match(mem_tag, r);

    always_comb begin
        sel = FWD_RF;
        if (use_r) begin
            if (ex_hit && ex_tag.link) begin
                sel = FWD_LINK;
            end else if (ex_hit && !ex_tag.load) begin
                sel = FWD_EXMEM;
            end else if (mem_hit) begin
                // An EX load that matches falls through here; the load-use
                // stall covers the real case, so this only sees MEM data.
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage pipeline.
// Tracks EX/MEM/WB destination tags, registers the two EX operand-mux
// selects, and stalls IF/ID for one cycle on a load-use hazard.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   id_valid                 ID holds a real instruction
//   id_rs, id_rt             ID source registers
//   id_use_rs, id_use_rt     ID instruction reads rs / rt
//   id_wa, id_we             ID destination register / write enable
//   id_load, id_link         ID instruction is a load / jal-jalr
//   flush                    redirect; kills the instruction leaving ID
//   stall                    freeze PC and IF/ID, bubble into EX
//   fwd_a_sel, fwd_b_sel     EX operand-mux selects (valid in EX cycle)
//   stall_cnt, fwd_cnt       performance counters
// Build option: FWD_PERF_EN enables the counters; otherwise they are 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal issue; load-use hazard check active
// ST_STALL | one bubble inserted; held ID instruction re-evaluates
module fwd_hazard_ctrl
    import fwd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_wa,
    input  logic              id_we,
    input  logic              id_load,
    input  logic              id_link,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt
);

    stage_tag_t       ex_tag;
    stage_tag_t       mem_tag;
    stage_tag_t       wb_tag;
    stage_tag_t       id_tag;
    state_t           state;
    state_t           state_nxt;
    logic             haz;
    logic             kill;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;

    // WB tag is tracked for visibility only: the regfile is write-before-read,
    // so nothing forwards from WB.
    logic unused_wb;
    assign unused_wb = ^wb_tag;

    assign id_tag = '{valid: id_valid, wa: id_wa, we: id_we, load: id_load, link: id_link};

    assign haz = id_valid & (state == ST_RUN) & ex_tag.load &
                 ((id_use_rs & tag_match(ex_tag, id_rs)) |
                  (id_use_rt & tag_match(ex_tag, id_rt)));

    assign stall = haz & ~flush;
    assign kill  = flush | stall;

    fwd_sel_calc u_sel_a (
        .use_r   (id_use_rs),
        .r       (id_rs),
        .ex_tag  (ex_tag),
        .mem_tag (mem_tag),
        .sel     (sel_a)
    );

    fwd_sel_calc u_sel_b (
        .use_r   (id_use_rt),
        .r       (id_rt),
        .ex_tag  (ex_tag),
        .mem_tag (mem_tag),
        .sel     (sel_b)
    );

    always_comb begin
        state_nxt = ST_RUN;
        case (state)
            ST_RUN:   state_nxt = stall ? ST_STALL : ST_RUN;
            ST_STALL: state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            ex_tag    <= TAG_BUBBLE;
            mem_tag   <= TAG_BUBBLE;
            wb_tag    <= TAG_BUBBLE;
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else begin
            state   <= state_nxt;
            mem_tag <= ex_tag;
            wb_tag  <= mem_tag;
            if (kill) begin
                ex_tag    <= TAG_BUBBLE;
                fwd_a_sel <= FWD_RF;
                fwd_b_sel <= FWD_RF;
            end else begin
                ex_tag    <= id_tag;
                fwd_a_sel <= sel_a;
                fwd_b_sel <= sel_b;
            end
        end
    end

`ifdef FWD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;
    logic [1:0]  fwd_inc;

    always_comb begin
        fwd_inc = 2'd0;
        if (!kill) begin
            fwd_inc = {1'b0, (sel_a != FWD_RF)} + {1'b0, (sel_b != FWD_RF)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + {31'd0, stall};
            fwd_cnt_q   <= fwd_cnt_q + {30'd0, fwd_inc};
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed test-plan sequences
// followed by randomized issue traffic, checked against an instruction
// history model.
module tb_fwd_hazard_ctrl;
    import fwd_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs, id_rt, id_wa;
    logic              id_use_rs, id_use_rt, id_we, id_load, id_link;
    logic              flush;
    logic              stall;
    logic [SEL_W-1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0]       stall_cnt, fwd_cnt;

    always #5 clk = ~clk;

    fwd_hazard_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_wa     (id_wa),
        .id_we     (id_we),
        .id_load   (id_load),
        .id_link   (id_link),
        .flush     (flush),
        .stall     (stall),
        .fwd_a_sel (fwd_a_sel),
        .fwd_b_sel (fwd_b_sel),
        .stall_cnt (stall_cnt),
        .fwd_cnt   (fwd_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the two most recent instructions that entered EX (bubbles
    // included), newest first, plus whether the last cycle stalled.
    typedef struct {
        bit v;
        int wa;
        bit we;
        bit ld;
        bit lk;
    } ins_t;

    ins_t        hist[2];
    bit          m_stalled_last;
    bit   [31:0] m_stall_cnt;
    bit   [31:0] m_fwd_cnt;
    logic        obs_stall;
    logic [2:0]  obs_a, obs_b;

    function automatic bit writes(input ins_t t, input int r);
        return t.v && t.we && (t.wa != 0) && (t.wa == r);
    endfunction

    function automatic int model_sel(input bit use_r, input int r);
        if (!use_r) return 0;
        if (writes(hist[0], r) && hist[0].lk) return 3;
        if (writes(hist[0], r) && !hist[0].ld) return 1;
        if (writes(hist[1], r)) return 2;
        return 0;
    endfunction

    function automatic ins_t mk(input bit v, input int wa, input bit we, input bit ld, input bit lk);
        ins_t t;
        t.v = v; t.wa = wa; t.we = we; t.ld = ld; t.lk = lk;
        return t;
    endfunction

    task automatic model_reset();
        hist[0] = mk(0, 0, 0, 0, 0);
        hist[1] = mk(0, 0, 0, 0, 0);
        m_stalled_last = 0;
        m_stall_cnt = 0;
        m_fwd_cnt = 0;
    endtask

    // One pipeline cycle: drive at negedge, check stall, then check the
    // registered selects and counters just after the rising edge.
    task automatic cycle(input ins_t in, input bit urs, input bit urt,
                         input int rs, input int rt, input bit fl);
        bit exp_stall;
        int ea, eb;
        @(negedge clk);
        id_valid  = in.v;
        id_wa     = in.wa[REG_AW-1:0];
        id_we     = in.we;
        id_load   = in.ld;
        id_link   = in.lk;
        id_use_rs = urs;
        id_use_rt = urt;
        id_rs     = rs[REG_AW-1:0];
        id_rt     = rt[REG_AW-1:0];
        flush     = fl;
        #1;
        exp_stall = in.v && !m_stalled_last && !fl && hist[0].ld &&
                    ((urs && writes(hist[0], rs)) || (urt && writes(hist[0], rt)));
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        obs_stall = stall;
        if (fl || exp_stall) begin
            ea = 0; eb = 0;
            hist[1] = hist[0];
            hist[0] = mk(0, 0, 0, 0, 0);
        end else begin
            ea = model_sel(urs, rs);
            eb = model_sel(urt, rt);
            hist[1] = hist[0];
            hist[0] = in;
        end
        m_stalled_last = exp_stall;
        m_stall_cnt += 32'(exp_stall);
        m_fwd_cnt   += 32'((ea != 0) + (eb != 0));
        @(posedge clk);
        #1;
        chk("fwd_a_sel", 32'(fwd_a_sel), ea);
        chk("fwd_b_sel", 32'(fwd_b_sel), eb);
`ifdef FWD_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall_cnt);
        chk("fwd_cnt", fwd_cnt, m_fwd_cnt);
`else
        chk("stall_cnt", stall_cnt, 32'd0);
        chk("fwd_cnt", fwd_cnt, 32'd0);
`endif
        obs_a = fwd_a_sel;
        obs_b = fwd_b_sel;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cycle(mk(0, 0, 0, 0, 0), 0, 0, 0, 0, 0);
    endtask

    ins_t        cur;
    bit          curs, curt, cfl;
    int          crs, crt;
    logic [31:0] fwd_before;

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_wa = 0;
        id_use_rs = 0; id_use_rt = 0; id_we = 0; id_load = 0; id_link = 0;
        flush = 0;
        model_reset();
        #12;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_a", 32'(fwd_a_sel), 32'd0);
        chk("rst_b", 32'(fwd_b_sel), 32'd0);
        chk("rst_scnt", stall_cnt, 32'd0);
        chk("rst_fcnt", fwd_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // add $3,$1,$2 ; sub $4,$3,$5
        nops(2);
        cycle(mk(1, 3, 1, 0, 0), 1, 1, 1, 2, 0);
        cycle(mk(1, 4, 1, 0, 0), 1, 1, 3, 5, 0);
        chk("alu_nostall", {31'd0, obs_stall}, 32'd0);
        chk("alu_a", 32'(obs_a), 32'd1);
        chk("alu_b", 32'(obs_b), 32'd0);

        // lw $3 ; add $4,$0,$3 (held one cycle)
        nops(2);
        cycle(mk(1, 3, 1, 1, 0), 1, 0, 1, 0, 0);
        cycle(mk(1, 4, 1, 0, 0), 1, 1, 0, 3, 0);
        chk("lu_stall", {31'd0, obs_stall}, 32'd1);
        chk("lu_bubble_b", 32'(obs_b), 32'd0);
        cycle(mk(1, 4, 1, 0, 0), 1, 1, 0, 3, 0);
        chk("lu_release", {31'd0, obs_stall}, 32'd0);
        chk("lu_b", 32'(obs_b), 32'd2);

        // jal ; addu $2,$31,$0
        nops(2);
        cycle(mk(1, 31, 1, 0, 1), 0, 0, 0, 0, 0);
        cycle(mk(1, 2, 1, 0, 0), 1, 1, 31, 0, 0);
        chk("link_a", 32'(obs_a), 32'd3);

        // writer of $0 then $0 reader
        nops(2);
        cycle(mk(1, 0, 1, 1, 0), 1, 1, 1, 2, 0);
        cycle(mk(1, 5, 1, 0, 0), 1, 1, 0, 0, 0);
        chk("r0_stall", {31'd0, obs_stall}, 32'd0);
        chk("r0_a", 32'(obs_a), 32'd0);
        chk("r0_b", 32'(obs_b), 32'd0);

        // add $3 ; add $3 ; or $5,$3,$3 -> newest wins
        nops(2);
        cycle(mk(1, 3, 1, 0, 0), 1, 1, 1, 2, 0);
        cycle(mk(1, 3, 1, 0, 0), 1, 1, 1, 2, 0);
        fwd_before = fwd_cnt;
        cycle(mk(1, 5, 1, 0, 0), 1, 1, 3, 3, 0);
        chk("newest_a", 32'(obs_a), 32'd1);
        chk("newest_b", 32'(obs_b), 32'd1);
`ifdef FWD_PERF_EN
        chk("newest_fcnt", fwd_cnt - fwd_before, 32'd2);
`endif

        // lw $3 ; dependent with flush
        nops(2);
        cycle(mk(1, 3, 1, 1, 0), 1, 0, 1, 0, 0);
        cycle(mk(1, 4, 1, 0, 0), 1, 1, 3, 3, 1);
        chk("fl_stall", {31'd0, obs_stall}, 32'd0);
        chk("fl_a", 32'(obs_a), 32'd0);
        chk("fl_b", 32'(obs_b), 32'd0);
        nops(1);

        // reset mid-stall
        nops(2);
        cycle(mk(1, 3, 1, 0, 0), 1, 1, 1, 2, 0);
        cycle(mk(1, 6, 1, 1, 0), 1, 0, 1, 0, 0);
        @(negedge clk);
        id_valid = 1; id_wa = 4; id_we = 1; id_load = 0; id_link = 0;
        id_use_rs = 1; id_use_rt = 1; id_rs = 6; id_rt = 3; flush = 0;
        #1;
        chk("mid_stall_pre", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_a", 32'(fwd_a_sel), 32'd0);
        chk("mid_rst_b", 32'(fwd_b_sel), 32'd0);
        chk("mid_rst_scnt", stall_cnt, 32'd0);
        chk("mid_rst_state", {31'd0, dut.state}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        // no stale forwarding of $3/$6 after release
        cycle(mk(1, 4, 1, 0, 0), 1, 1, 6, 3, 0);
        chk("post_rst_a", 32'(obs_a), 32'd0);
        chk("post_rst_b", 32'(obs_b), 32'd0);

        // randomized traffic; a stalled ID instruction is held
        cur = mk(0, 0, 0, 0, 0);
        curs = 0; curt = 0; crs = 0; crt = 0;
        for (int n = 0; n < 600; n++) begin
            if (!obs_stall) begin
                cur.v  = ($urandom_range(0, 7) != 0);
                cur.lk = ($urandom_range(0, 9) == 0);
                cur.ld = !cur.lk && ($urandom_range(0, 2) == 0);
                cur.we = cur.lk || ($urandom_range(0, 4) != 0);
                cur.wa = cur.lk ? 31 : int'($urandom_range(0, 3));
                curs = $urandom_range(0, 3) != 0;
                curt = $urandom_range(0, 1) != 0;
                crs  = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 3));
                crt  = int'($urandom_range(0, 3));
            end
            cfl = ($urandom_range(0, 9) == 0);
            cycle(cur, curs, curt, crs, crt, cfl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
